multicycle_ctrl: RTL and testbench
==================================

Name: multicycle_ctrl

Overview:
Control unit for the team's next-generation multi-cycle CPU. It replaces the single-cycle combinational decoder with a Moore FSM that sequences FETCH, DECODE, EXECUTE, MEM and WRITEBACK over a shared datapath and a single shared instruction/data memory port. The memory port uses a req/ack handshake with a bounded wait-state timeout. The block also keeps a retired-instruction counter and flags illegal opcodes and bus errors.

Parameters:
TIMEOUT_CYC, 16, max cycles mem_req_o may wait for mem_ack_i before bus error (≥2)
RET_W, 32, width of retired-instruction counter

Ports:
clk_i  in  1  clock, rising edge
rst_i  in  1  synchronous, active-low reset
opcode_i  in  6  IR[31:26], valid from DECODE onward
funct_i  in  6  IR[5:0]
mem_ack_i  in  1  memory completes the current request this cycle
mem_req_o  out  1  memory access request
mem_we_o  out  1  write (sw) when mem_req_o=1
iord_o  out  1  0: address=PC, 1: address=ALUOut
ir_write_o  out  1  load IR
pc_write_o  out  1  unconditional PC load
pc_write_cond_o  out  1  PC load if branch condition holds
branch_ne_o  out  1  condition is !zero (bne); else zero (beq)
pc_src_o  out  2  00 ALU result, 01 ALUOut, 10 jump target, 11 rs
alu_src_a_o  out  1  0 PC, 1 rs
alu_src_b_o  out  2  00 rt, 01 const 4, 10 sext imm, 11 sext imm<<2
alu_op_o  out  3  000 add, 001 sub, 010 funct-decoded, 011 slt
reg_write_o  out  1  register file write enable
reg_dst_o  out  2  00 rt, 01 rd, 10 $31
mem_to_reg_o  out  2  00 ALUOut, 01 MDR, 10 PC
instr_done_o  out  1  one-cycle pulse on the final cycle of each instruction
retired_o  out  RET_W  count of completed instructions
exc_o  out  1  sticky: illegal opcode
err_o  out  1  sticky: memory timeout

Behaviour:
- Reset (rst_i=0 at an edge): state←FETCH, wait counter←0, retired_o←0, exc_o←0, err_o←0. Reset wins over every other event, including in the middle of a handshake.
- All control outputs are combinational functions of state only (Moore); mem_ack_i affects only the next state and the strobes gated in ack cycles.
- Outputs not listed for a state are 0.
- FETCH:
  - Signals: mem_req_o=1, iord_o=0, alu_src_a_o=0, alu_src_b_o=01, alu_op_o=add, pc_src_o=00.
  - ir_write_o and pc_write_o equal mem_ack_i.
  - On ack, go to DECODE.
- DECODE: alu_src_a_o=0, alu_src_b_o=11, alu_op_o=add (branch target into ALUOut). Dispatch:
  - R-type, funct≠001000 → EXEC_R
  - jr (R-type, funct=001000) → JR
  - addi (001000) → EXEC_I
  - slti (001010) → EXEC_I
  - lw (100011) / sw (101011) → MEM_ADDR
  - beq (000100) / bne (000101) → BRANCH
  - j (000010) / jal (000011) → JUMP
  - any other opcode → HALT with exc_o←1
- EXEC_R: src_a=1, src_b=00, alu_op=010 → WB_R.
- WB_R: reg_write_o=1, reg_dst_o=01, mem_to_reg_o=00, instr_done_o=1 → FETCH.
- EXEC_I: src_a=1, src_b=10, alu_op=add (addi) or 011 (slti) → WB_I.
- WB_I: reg_write_o=1, reg_dst_o=00, instr_done_o=1 → FETCH.
- MEM_ADDR: src_a=1, src_b=10, add → MEM_RD (lw) or MEM_WR (sw).
- MEM_RD: mem_req_o=1, iord_o=1. On ack → MEM_WB.
- MEM_WB: reg_write_o=1, reg_dst_o=00, mem_to_reg_o=01, instr_done_o=1 → FETCH.
- MEM_WR: mem_req_o=1, mem_we_o=1, iord_o=1. On ack, instr_done_o=1 → FETCH.
- BRANCH: src_a=1, src_b=00, alu_op=sub, pc_write_cond_o=1, pc_src_o=01, branch_ne_o=(bne), instr_done_o=1 → FETCH.
- JUMP:
  - pc_write_o=1, pc_src_o=10, instr_done_o=1 → FETCH.
  - For jal, also reg_write_o=1, reg_dst_o=10, mem_to_reg_o=10. PC already holds PC+4 at this point.
- JR: pc_write_o=1, pc_src_o=11, instr_done_o=1 → FETCH.
- HALT: absorbing until reset. All enables 0, no mem_req_o.
- Zero-wait latency (ack in the first req cycle):
  - 3 cycles: beq, bne, j, jal, jr
  - 4 cycles: R-type, addi, slti, sw
  - 5 cycles: lw
  - Each wait cycle adds 1.
- Handshake and timeout:
  - mem_req_o and the address/we selects stay stable until the ack cycle.
  - The wait counter increments on each req cycle without ack and clears on ack or on leaving the state.
  - If counter=TIMEOUT_CYC-1 with no ack → HALT, err_o←1.
  - An ack arriving in that same cycle wins: normal completion.
- retired_o increments on each instr_done_o and wraps modulo 2^RET_W.

Decomposition:
- Package mc_pkg: state enum (FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR, MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JR, HALT), opcode/funct constants, and the alu_op/pc_src/alu_src_b/reg_dst/mem_to_reg encodings.
- One sub-module: mc_wait_timer (counter plus timeout compare, parameter TIMEOUT_CYC).

Test Plan:
- R-type add, ack held 1 → states FETCH, DECODE, EXEC_R, WB_R; reg_write_o=1 with reg_dst_o=01 in cycle 4; instr_done_o pulses once; retired_o=1.
- lw with ack arriving on the 3rd fetch cycle and the 2nd MEM_RD cycle → mem_req_o high 3 and 2 cycles respectively; total 8 cycles; mem_to_reg_o=01 at writeback.
- TIMEOUT_CYC=4, mem_ack_i=0 → mem_req_o high for exactly 4 cycles, then HALT with err_o=1, mem_req_o=0 thereafter. Repeat with ack in the 4th cycle → no error.
- opcode 111111 → HALT after DECODE, exc_o=1, no instr_done_o, retired_o unchanged; rst_i=0 for one edge → FETCH, exc_o=0.
- bne then jal → BRANCH shows pc_write_cond_o=1, branch_ne_o=1, pc_src_o=01; JUMP shows reg_dst_o=10, mem_to_reg_o=10, pc_src_o=10.
- RET_W=4, 17 zero-wait j instructions → retired_o=1. Reset asserted during MEM_WR wait → next cycle FETCH, mem_we_o=0, retired_o=0.

Source files
------------

// File: rtl/multicycle_ctrl_pkg.sv
// rtl/multicycle_ctrl_pkg.sv - states, opcodes and datapath select encodings for the multi-cycle controller
package mc_pkg;

  typedef enum logic [3:0] {
    FETCH, DECODE, EXEC_R, WB_R, EXEC_I, WB_I, MEM_ADDR,
    MEM_RD, MEM_WB, MEM_WR, BRANCH, JUMP, JR, HALT
  } state_t;

  localparam logic [5:0] OP_RTYPE = 6'b000000;
  localparam logic [5:0] OP_J     = 6'b000010;
  localparam logic [5:0] OP_JAL   = 6'b000011;
  localparam logic [5:0] OP_BEQ   = 6'b000100;
  localparam logic [5:0] OP_BNE   = 6'b000101;
  localparam logic [5:0] OP_ADDI  = 6'b001000;
  localparam logic [5:0] OP_SLTI  = 6'b001010;
  localparam logic [5:0] OP_LW    = 6'b100011;
  localparam logic [5:0] OP_SW    = 6'b101011;
  localparam logic [5:0] FN_JR    = 6'b001000;

  localparam logic [2:0] ALU_ADD   = 3'b000;
  localparam logic [2:0] ALU_SUB   = 3'b001;
  localparam logic [2:0] ALU_FUNCT = 3'b010;
  localparam logic [2:0] ALU_SLT   = 3'b011;

  localparam logic [1:0] PC_ALU    = 2'b00;
  localparam logic [1:0] PC_ALUOUT = 2'b01;
  localparam logic [1:0] PC_JUMP   = 2'b10;
  localparam logic [1:0] PC_RS     = 2'b11;

  localparam logic [1:0] SRCB_RT     = 2'b00;
  localparam logic [1:0] SRCB_FOUR   = 2'b01;
  localparam logic [1:0] SRCB_IMM    = 2'b10;
  localparam logic [1:0] SRCB_IMM_SH = 2'b11;

  localparam logic [1:0] RD_RT = 2'b00;
  localparam logic [1:0] RD_RD = 2'b01;
  localparam logic [1:0] RD_RA = 2'b10;

  localparam logic [1:0] M2R_ALUOUT = 2'b00;
  localparam logic [1:0] M2R_MDR    = 2'b01;
  localparam logic [1:0] M2R_PC     = 2'b10;

  // Unknown opcodes fall into HALT; the caller flags them as exceptions.
  function automatic state_t decode_dispatch(input logic [5:0] opcode, input logic [5:0] funct);
    state_t s;
    case (opcode)
      OP_RTYPE: begin
        if (funct == FN_JR) s = JR;
        else                s = EXEC_R;
      end
      OP_ADDI, OP_SLTI: s = EXEC_I;
      OP_LW, OP_SW:     s = MEM_ADDR;
      OP_BEQ, OP_BNE:   s = BRANCH;
      OP_J, OP_JAL:     s = JUMP;
      default:          s = HALT;
    endcase
    return s;
  endfunction

endpackage

// File: rtl/multicycle_ctrl_if.sv
// rtl/multicycle_ctrl_if.sv - shared instruction/data memory port with req/ack handshake
interface multicycle_ctrl_if;
  logic mem_req_o;
  logic mem_we_o;
  logic iord_o;
  logic mem_ack_i;

  modport master (output mem_req_o, output mem_we_o, output iord_o, input mem_ack_i);
  modport slave  (input mem_req_o, input mem_we_o, input iord_o, output mem_ack_i);
endinterface

// File: rtl/multicycle_ctrl_wait_timer.sv
// rtl/multicycle_ctrl_wait_timer.sv - wait-state counter with timeout compare for the memory handshake
module mc_wait_timer #(
  parameter int TIMEOUT_CYC = 16
) (
  input  logic clk_i,
  input  logic rst_i,
  input  logic req,
  input  logic ack,
  output logic timeout
);

  localparam int CW = (TIMEOUT_CYC > 2) ? $clog2(TIMEOUT_CYC) : 1;

  logic [CW-1:0] cnt;

  // An ack in the final wait cycle still counts as a normal completion.
  assign timeout = req && !ack && (cnt == CW'(TIMEOUT_CYC - 1));

  always_ff @(posedge clk_i) begin
    if (!rst_i || !req || ack || timeout) cnt <= '0;
    else                                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/multicycle_ctrl.sv
// rtl/multicycle_ctrl.sv - Moore FSM control unit for the multi-cycle CPU with retired count and error flags
module multicycle_ctrl
  import mc_pkg::*;
#(
  parameter int TIMEOUT_CYC = 16,
  parameter int RET_W       = 32
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  input  logic [5:0]           opcode_i,
  input  logic [5:0]           funct_i,
  multicycle_ctrl_if.master    mem,
  output logic                 ir_write_o,
  output logic                 pc_write_o,
  output logic                 pc_write_cond_o,
  output logic                 branch_ne_o,
  output logic [1:0]           pc_src_o,
  output logic                 alu_src_a_o,
  output logic [1:0]           alu_src_b_o,
  output logic [2:0]           alu_op_o,
  output logic                 reg_write_o,
  output logic [1:0]           reg_dst_o,
  output logic [1:0]           mem_to_reg_o,
  output logic                 instr_done_o,
  output logic [RET_W-1:0]     retired_o,
  output logic                 exc_o,
  output logic                 err_o
);

  state_t state, state_nxt;
  logic   mem_req, mem_we, iord;
  logic   ack, timeout;

  assign ack           = mem.mem_ack_i;
  assign mem.mem_req_o = mem_req;
  assign mem.mem_we_o  = mem_we;
  assign mem.iord_o    = iord;

  mc_wait_timer #(.TIMEOUT_CYC(TIMEOUT_CYC)) u_wait_timer (
    .clk_i   (clk_i),
    .rst_i   (rst_i),
    .req     (mem_req),
    .ack     (ack),
    .timeout (timeout)
  );

  always_ff @(posedge clk_i) begin
    if (!rst_i) state <= FETCH;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      FETCH: begin
        if (ack)          state_nxt = DECODE;
        else if (timeout) state_nxt = HALT;
      end
      DECODE:   state_nxt = decode_dispatch(opcode_i, funct_i);
      EXEC_R:   state_nxt = WB_R;
      EXEC_I:   state_nxt = WB_I;
      MEM_ADDR: state_nxt = (opcode_i == OP_SW) ? MEM_WR : MEM_RD;
      MEM_RD: begin
        if (ack)          state_nxt = MEM_WB;
        else if (timeout) state_nxt = HALT;
      end
      MEM_WR: begin
        if (ack)          state_nxt = FETCH;
        else if (timeout) state_nxt = HALT;
      end
      WB_R, WB_I, MEM_WB, BRANCH, JUMP, JR: state_nxt = FETCH;
      HALT:     state_nxt = HALT;
      default:  state_nxt = FETCH;
    endcase
  end

  always_comb begin
    mem_req         = 1'b0;
    mem_we          = 1'b0;
    iord            = 1'b0;
    ir_write_o      = 1'b0;
    pc_write_o      = 1'b0;
    pc_write_cond_o = 1'b0;
    branch_ne_o     = 1'b0;
    pc_src_o        = PC_ALU;
    alu_src_a_o     = 1'b0;
    alu_src_b_o     = SRCB_RT;
    alu_op_o        = ALU_ADD;
    reg_write_o     = 1'b0;
    reg_dst_o       = RD_RT;
    mem_to_reg_o    = M2R_ALUOUT;
    instr_done_o    = 1'b0;
    case (state)
      FETCH: begin
        mem_req     = 1'b1;
        alu_src_b_o = SRCB_FOUR;
        ir_write_o  = ack;
        pc_write_o  = ack;
      end
      DECODE: alu_src_b_o = SRCB_IMM_SH;
      EXEC_R: begin
        alu_src_a_o = 1'b1;
        alu_op_o    = ALU_FUNCT;
      end
      WB_R: begin
        reg_write_o  = 1'b1;
        reg_dst_o    = RD_RD;
        instr_done_o = 1'b1;
      end
      EXEC_I: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
        alu_op_o    = (opcode_i == OP_SLTI) ? ALU_SLT : ALU_ADD;
      end
      WB_I: begin
        reg_write_o  = 1'b1;
        instr_done_o = 1'b1;
      end
      MEM_ADDR: begin
        alu_src_a_o = 1'b1;
        alu_src_b_o = SRCB_IMM;
      end
      MEM_RD: begin
        mem_req = 1'b1;
        iord    = 1'b1;
      end
      MEM_WB: begin
        reg_write_o  = 1'b1;
        mem_to_reg_o = M2R_MDR;
        instr_done_o = 1'b1;
      end
      MEM_WR: begin
        mem_req      = 1'b1;
        mem_we       = 1'b1;
        iord         = 1'b1;
        instr_done_o = ack;
      end
      BRANCH: begin
        alu_src_a_o     = 1'b1;
        alu_op_o        = ALU_SUB;
        pc_write_cond_o = 1'b1;
        pc_src_o        = PC_ALUOUT;
        branch_ne_o     = (opcode_i == OP_BNE);
        instr_done_o    = 1'b1;
      end
      JUMP: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PC_JUMP;
        instr_done_o = 1'b1;
        // PC already advanced in FETCH, so the link value is PC itself.
        if (opcode_i == OP_JAL) begin
          reg_write_o  = 1'b1;
          reg_dst_o    = RD_RA;
          mem_to_reg_o = M2R_PC;
        end
      end
      JR: begin
        pc_write_o   = 1'b1;
        pc_src_o     = PC_RS;
        instr_done_o = 1'b1;
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i) begin
      retired_o <= '0;
      exc_o     <= 1'b0;
      err_o     <= 1'b0;
    end else begin
      if (instr_done_o)                          retired_o <= retired_o + RET_W'(1);
      if (state == DECODE && state_nxt == HALT)  exc_o     <= 1'b1;
      if (timeout)                               err_o     <= 1'b1;
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// tb/tb_multicycle_ctrl.sv - randomized self-checking bench for multicycle_ctrl against a per-cycle expectation queue
module tb_multicycle_ctrl;

  localparam int T  = 4;
  localparam int RW = 4;

  localparam logic [5:0] OP_R    = 6'h00;
  localparam logic [5:0] OP_J    = 6'h02;
  localparam logic [5:0] OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04;
  localparam logic [5:0] OP_BNE  = 6'h05;
  localparam logic [5:0] OP_ADDI = 6'h08;
  localparam logic [5:0] OP_SLTI = 6'h0A;
  localparam logic [5:0] OP_LW   = 6'h23;
  localparam logic [5:0] OP_SW   = 6'h2B;

  typedef struct packed {
    logic       req, we, iord, irw, pcw, pcwc, bne;
    logic [1:0] pc_src;
    logic       src_a;
    logic [1:0] src_b;
    logic [2:0] alu;
    logic       regw;
    logic [1:0] reg_dst, m2r;
    logic       done;
  } ctrl_t;

  typedef struct {
    logic  ack;
    ctrl_t exp;
    logic  set_exc, set_err;
  } cyc_t;

  logic clk = 1'b0;
  logic rst;
  logic [5:0] opcode, funct;
  logic ir_write, pc_write, pc_write_cond, branch_ne, alu_src_a, reg_write, instr_done, exc, err;
  logic [1:0] pc_src, alu_src_b, reg_dst, mem_to_reg;
  logic [2:0] alu_op;
  logic [RW-1:0] retired;

  multicycle_ctrl_if mem();

  multicycle_ctrl #(.TIMEOUT_CYC(T), .RET_W(RW)) dut (
    .clk_i(clk), .rst_i(rst), .opcode_i(opcode), .funct_i(funct), .mem(mem),
    .ir_write_o(ir_write), .pc_write_o(pc_write), .pc_write_cond_o(pc_write_cond),
    .branch_ne_o(branch_ne), .pc_src_o(pc_src), .alu_src_a_o(alu_src_a),
    .alu_src_b_o(alu_src_b), .alu_op_o(alu_op), .reg_write_o(reg_write),
    .reg_dst_o(reg_dst), .mem_to_reg_o(mem_to_reg), .instr_done_o(instr_done),
    .retired_o(retired), .exc_o(exc), .err_o(err)
  );

  always #5 clk = ~clk;

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  int   n_checks = 0;
  int   n_pass   = 0;
  int   model_ret;
  logic model_exc, model_err;
  cyc_t q[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)", tag, act, exp, $time);
  endtask

  function automatic ctrl_t sample();
    ctrl_t c;
    c.req = mem.mem_req_o; c.we = mem.mem_we_o; c.iord = mem.iord_o;
    c.irw = ir_write; c.pcw = pc_write; c.pcwc = pc_write_cond; c.bne = branch_ne;
    c.pc_src = pc_src; c.src_a = alu_src_a; c.src_b = alu_src_b; c.alu = alu_op;
    c.regw = reg_write; c.reg_dst = reg_dst; c.m2r = mem_to_reg; c.done = instr_done;
    return c;
  endfunction

  function automatic logic rnd();
    return logic'($urandom_range(0, 1));
  endfunction

  // Memory-request phases: 0 instruction fetch, 1 load read, 2 store write.
  function automatic ctrl_t req_c(input int kind, input logic ack);
    ctrl_t c = '0;
    c.req = 1'b1;
    if (kind == 0) begin
      c.src_b = 2'b01; c.irw = ack; c.pcw = ack;
    end else begin
      c.iord = 1'b1;
      if (kind == 2) begin c.we = 1'b1; c.done = ack; end
    end
    return c;
  endfunction

  task automatic push(input ctrl_t c, input logic ack, input logic se, input logic sr);
    cyc_t e;
    e.ack = ack; e.exp = c; e.set_exc = se; e.set_err = sr;
    q.push_back(e);
  endtask

  task automatic push_halt();
    for (int i = 0; i < 3; i++) push('0, rnd(), 1'b0, 1'b0);
  endtask

  // w no-ack cycles then an ack; waiting T cycles without ack is a bus error.
  task automatic push_req(input int kind, input int w, output bit ok);
    int n = (w >= T) ? T : w;
    for (int i = 0; i < n; i++) push(req_c(kind, 1'b0), 1'b0, 1'b0, (w >= T) && (i == n - 1));
    ok = (w < T);
    if (ok) push(req_c(kind, 1'b1), 1'b1, 1'b0, 1'b0);
  endtask

  task automatic build_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                             output bit halted);
    bit    ok;
    bit    legal;
    ctrl_t c;
    halted = 1'b0;
    push_req(0, fw, ok);
    if (!ok) begin halted = 1'b1; push_halt(); return; end
    legal = op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW};
    c = '0; c.src_b = 2'b11;
    push(c, rnd(), !legal, 1'b0);
    case (op)
      OP_R: begin
        if (fn == 6'b001000) begin
          c = '0; c.pcw = 1'b1; c.pc_src = 2'b11; c.done = 1'b1; push(c, rnd(), 1'b0, 1'b0);
        end else begin
          c = '0; c.src_a = 1'b1; c.alu = 3'b010; push(c, rnd(), 1'b0, 1'b0);
          c = '0; c.regw = 1'b1; c.reg_dst = 2'b01; c.done = 1'b1; push(c, rnd(), 1'b0, 1'b0);
        end
      end
      OP_ADDI, OP_SLTI: begin
        c = '0; c.src_a = 1'b1; c.src_b = 2'b10; c.alu = (op == OP_SLTI) ? 3'b011 : 3'b000;
        push(c, rnd(), 1'b0, 1'b0);
        c = '0; c.regw = 1'b1; c.done = 1'b1; push(c, rnd(), 1'b0, 1'b0);
      end
      OP_LW, OP_SW: begin
        c = '0; c.src_a = 1'b1; c.src_b = 2'b10; push(c, rnd(), 1'b0, 1'b0);
        push_req((op == OP_SW) ? 2 : 1, mw, ok);
        if (!ok) begin halted = 1'b1; push_halt(); end
        else if (op == OP_LW) begin
          c = '0; c.regw = 1'b1; c.m2r = 2'b01; c.done = 1'b1; push(c, rnd(), 1'b0, 1'b0);
        end
      end
      OP_BEQ, OP_BNE: begin
        c = '0; c.src_a = 1'b1; c.alu = 3'b001; c.pcwc = 1'b1; c.pc_src = 2'b01;
        c.bne = (op == OP_BNE); c.done = 1'b1; push(c, rnd(), 1'b0, 1'b0);
      end
      OP_J, OP_JAL: begin
        c = '0; c.pcw = 1'b1; c.pc_src = 2'b10; c.done = 1'b1;
        if (op == OP_JAL) begin c.regw = 1'b1; c.reg_dst = 2'b10; c.m2r = 2'b10; end
        push(c, rnd(), 1'b0, 1'b0);
      end
      default: begin halted = 1'b1; push_halt(); end
    endcase
  endtask

  task automatic run_q(input int max_cyc);
    cyc_t e;
    int   n = 0;
    while (q.size() > 0 && (max_cyc < 0 || n < max_cyc)) begin
      e = q.pop_front();
      @(negedge clk);
      mem.mem_ack_i = e.ack;
      #1;
      check("ctrl", 32'(sample()), 32'(e.exp));
      check("retired", 32'(retired), 32'(model_ret));
      check("exc", 32'(exc), 32'(model_exc));
      check("err", 32'(err), 32'(model_err));
      if (e.exp.done) model_ret = (model_ret + 1) % (1 << RW);
      if (e.set_exc) model_exc = 1'b1;
      if (e.set_err) model_err = 1'b1;
      n++;
    end
    q.delete();
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b0;
    mem.mem_ack_i = rnd();
    @(posedge clk);
    #1;
    mem.mem_ack_i = 1'b0;
    #1;
    model_ret = 0; model_exc = 1'b0; model_err = 1'b0;
    check("rst_ctrl", 32'(sample()), 32'(req_c(0, 1'b0)));
    check("rst_retired", 32'(retired), 32'd0);
    check("rst_exc", 32'(exc), 32'd0);
    check("rst_err", 32'(err), 32'd0);
    rst = 1'b1;
  endtask

  task automatic run_instr(input logic [5:0] op, input logic [5:0] fn, input int fw, input int mw,
                           output bit halted);
    opcode = op; funct = fn;
    build_instr(op, fn, fw, mw, halted);
    run_q(-1);
  endtask

  initial begin
    bit            h;
    logic [5:0]    op, fn;
    int            fw, mw;
    logic [5:0]    ops [9] = '{OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW};

    rst = 1'b0; opcode = '0; funct = '0; mem.mem_ack_i = 1'b0;
    model_ret = 0; model_exc = 1'b0; model_err = 1'b0;
    do_reset();

    run_instr(OP_R, 6'h20, 0, 0, h);
    run_instr(OP_LW, 6'h00, 2, 1, h);
    run_instr(OP_J, 6'h00, T, 0, h);
    do_reset();
    run_instr(OP_J, 6'h00, T - 1, 0, h);
    run_instr(OP_LW, 6'h00, 0, T - 1, h);
    run_instr(OP_SW, 6'h00, 0, T, h);
    do_reset();
    run_instr(6'b111111, 6'h00, 0, 0, h);
    do_reset();
    run_instr(OP_BNE, 6'h00, 0, 0, h);
    run_instr(OP_JAL, 6'h00, 0, 0, h);
    run_instr(OP_R, 6'b001000, 1, 0, h);

    do_reset();
    for (int i = 0; i < 17; i++) run_instr(OP_J, 6'h00, 0, 0, h);
    @(posedge clk);
    #1;
    check("wrap", 32'(retired), 32'd1);

    opcode = OP_SW; funct = '0;
    build_instr(OP_SW, 6'h00, 0, T - 1, h);
    run_q(5);
    do_reset();
    check("rst_we", 32'(mem.mem_we_o), 32'd0);

    for (int k = 0; k < 250; k++) begin
      if ($urandom_range(0, 19) == 0) begin
        do op = 6'($urandom); while (op inside {OP_R, OP_J, OP_JAL, OP_BEQ, OP_BNE, OP_ADDI, OP_SLTI, OP_LW, OP_SW});
      end else begin
        op = ops[$urandom_range(0, 8)];
      end
      fn = ($urandom_range(0, 3) == 0) ? 6'b001000 : 6'($urandom);
      fw = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, 2);
      mw = ($urandom_range(0, 9) == 0) ? T + $urandom_range(0, 1) : $urandom_range(0, T - 1);
      run_instr(op, fn, fw, mw, h);
      if (h) do_reset();
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule
